// File: rtl/alu_share_arbiter_if.sv
// Per-requester handshake bundle for the shared ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 2
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [OP_W-1:0]  req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one combinational ALU.
// Round-robin or fixed priority grant, one registered response slot per port.
module alu_share_arbiter #(
  parameter int WIDTH      = 16,
  parameter int OP_W       = 2,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  alu_share_arbiter_if.slave p0,
  alu_share_arbiter_if.slave p1,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [WIDTH-1:0]  alu_result
);

  logic             last_grant;
  logic             elig0;
  logic             elig1;
  logic             gnt0;
  logic             gnt1;
  logic             v0;
  logic             v1;
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r1;

  // A slot draining this cycle can take a new request.
  assign elig0 = p0.req_valid && (!v0 || p0.rsp_ready);
  assign elig1 = p1.req_valid && (!v1 || p1.rsp_ready);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case ({elig1, elig0})
      2'b11: begin
        if (FIXED_PRIO || last_grant) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end
      2'b01:   gnt0 = 1'b1;
      2'b10:   gnt1 = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = {OP_W{1'b1}};
    if (gnt0) begin
      alu_a  = p0.req_a;
      alu_b  = p0.req_b;
      alu_op = p0.req_op;
    end else if (gnt1) begin
      alu_a  = p1.req_a;
      alu_b  = p1.req_b;
      alu_op = p1.req_op;
    end
  end

  assign p0.req_ready  = gnt0;
  assign p1.req_ready  = gnt1;
  assign p0.rsp_valid  = v0;
  assign p1.rsp_valid  = v1;
  assign p0.rsp_result = r0;
  assign p1.rsp_result = r1;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      v0         <= 1'b0;
      v1         <= 1'b0;
      r0         <= '0;
      r1         <= '0;
    end else begin
      if (gnt0) begin
        last_grant <= 1'b0;
      end else if (gnt1) begin
        last_grant <= 1'b1;
      end

      if (gnt0) begin
        v0 <= 1'b1;
        r0 <= alu_result;
      end else if (p0.rsp_ready) begin
        v0 <= 1'b0;
      end

      if (gnt1) begin
        v1 <= 1'b1;
        r1 <= alu_result;
      end else if (p1.rsp_ready) begin
        v1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: round-robin and fixed-priority instances,
// a cycle-level reference model plus directed literal expectations.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  alu_share_arbiter_if #(.WIDTH(16), .OP_W(2)) i0 ();
  alu_share_arbiter_if #(.WIDTH(16), .OP_W(2)) i1 ();
  alu_share_arbiter_if #(.WIDTH(16), .OP_W(2)) f0 ();
  alu_share_arbiter_if #(.WIDTH(16), .OP_W(2)) f1 ();

  logic [15:0] rr_aa, rr_ab, rr_res;
  logic [1:0]  rr_aop;
  logic [15:0] fp_aa, fp_ab, fp_res;
  logic [1:0]  fp_aop;

  function automatic logic [15:0] alu_ref(
    input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a + b;
      2'b10:   return a - b;
      default: return 16'h0000;
    endcase
  endfunction

  assign rr_res = alu_ref(rr_aa, rr_ab, rr_aop);
  assign fp_res = alu_ref(fp_aa, fp_ab, fp_aop);

  alu_share_arbiter #(.WIDTH(16), .OP_W(2), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .reset(reset), .p0(i0), .p1(i1),
    .alu_a(rr_aa), .alu_b(rr_ab), .alu_op(rr_aop), .alu_result(rr_res)
  );

  alu_share_arbiter #(.WIDTH(16), .OP_W(2), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .reset(reset), .p0(f0), .p1(f1),
    .alu_a(fp_aa), .alu_b(fp_ab), .alu_op(fp_aop), .alu_result(fp_res)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // Reference model, per instance d: response slots and the port that
  // wins the next conflict.
  bit          m_live [2];
  bit          m_val  [2][2];
  logic [15:0] m_res  [2][2];
  int          m_pref [2];

  task automatic model_step(
    input int d,
    input logic [1:0] v,
    input logic [1:0][15:0] a,
    input logic [1:0][15:0] b,
    input logic [1:0][1:0] op,
    input logic [1:0] rr,
    input logic [1:0] o_rdy,
    input logic [1:0] o_val,
    input logic [1:0][15:0] o_res,
    input logic [15:0] o_aa,
    input logic [15:0] o_ab,
    input logic [1:0] o_aop);
    bit elig [2];
    int win;
    if (reset) begin
      m_live[d] = 1'b1;
      m_pref[d] = 0;
      for (int p = 0; p < 2; p++) begin
        m_val[d][p] = 1'b0;
        m_res[d][p] = 16'h0;
      end
      return;
    end
    if (!m_live[d]) return;
    for (int p = 0; p < 2; p++)
      elig[p] = v[p] && (!m_val[d][p] || rr[p]);
    win = -1;
    if (elig[0] && elig[1]) win = (d == 1) ? 0 : m_pref[d];
    else if (elig[0]) win = 0;
    else if (elig[1]) win = 1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("d%0d_ready%0d", d, p), 32'(o_rdy[p]), 32'(win == p));
      chk($sformatf("d%0d_valid%0d", d, p), 32'(o_val[p]), 32'(m_val[d][p]));
      chk($sformatf("d%0d_result%0d", d, p), 32'(o_res[p]), 32'(m_res[d][p]));
    end
    if (win >= 0) begin
      chk($sformatf("d%0d_alu_a", d), 32'(o_aa), 32'(a[win]));
      chk($sformatf("d%0d_alu_b", d), 32'(o_ab), 32'(b[win]));
      chk($sformatf("d%0d_alu_op", d), 32'(o_aop), 32'(op[win]));
      m_pref[d] = 1 - win;
    end else begin
      chk($sformatf("d%0d_alu_idle", d), {14'h0, o_aop, o_aa}, 32'h0003_0000);
      chk($sformatf("d%0d_alu_b_idle", d), 32'(o_ab), 32'h0);
    end
    for (int p = 0; p < 2; p++) begin
      if (win == p) begin
        m_val[d][p] = 1'b1;
        m_res[d][p] = alu_ref(a[p], b[p], op[p]);
      end else if (m_val[d][p] && rr[p]) begin
        m_val[d][p] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, {i1.req_valid, i0.req_valid}, {i1.req_a, i0.req_a},
      {i1.req_b, i0.req_b}, {i1.req_op, i0.req_op},
      {i1.rsp_ready, i0.rsp_ready}, {i1.req_ready, i0.req_ready},
      {i1.rsp_valid, i0.rsp_valid}, {i1.rsp_result, i0.rsp_result},
      rr_aa, rr_ab, rr_aop);
    model_step(1, {f1.req_valid, f0.req_valid}, {f1.req_a, f0.req_a},
      {f1.req_b, f0.req_b}, {f1.req_op, f0.req_op},
      {f1.rsp_ready, f0.rsp_ready}, {f1.req_ready, f0.req_ready},
      {f1.rsp_valid, f0.rsp_valid}, {f1.rsp_result, f0.rsp_result},
      fp_aa, fp_ab, fp_aop);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int d, input int p, input logic v,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op);
    if (d == 0 && p == 0) begin
      i0.req_valid = v; i0.req_a = a; i0.req_b = b; i0.req_op = op;
    end else if (d == 0) begin
      i1.req_valid = v; i1.req_a = a; i1.req_b = b; i1.req_op = op;
    end else if (p == 0) begin
      f0.req_valid = v; f0.req_a = a; f0.req_b = b; f0.req_op = op;
    end else begin
      f1.req_valid = v; f1.req_a = a; f1.req_b = b; f1.req_op = op;
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        set_port(d, p, 1'b0, 16'h0, 16'h0, 2'b00);
    i0.rsp_ready = 1'b1; i1.rsp_ready = 1'b1;
    f0.rsp_ready = 1'b1; f1.rsp_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_valid0", 32'(i0.rsp_valid), 32'h0);
    chk("rst_result0", 32'(i0.rsp_result), 32'h0);
    chk("rst_valid1", 32'(i1.rsp_valid), 32'h0);
    chk("rst_result1", 32'(i1.rsp_result), 32'h0);

    // Single request, latency 1
    set_port(0, 0, 1'b1, 16'd30, 16'd30, 2'b01);
    #1 chk("t1_grant", 32'(i0.req_ready), 32'h1);
    tick();
    set_port(0, 0, 1'b0, 16'h0, 16'h0, 2'b00);
    #1;
    chk("t1_valid", 32'(i0.rsp_valid), 32'h1);
    chk("t1_result", 32'(i0.rsp_result), 32'd60);
    tick();

    // Conflict after reset alternates starting at port 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_port(0, 0, 1'b1, -16'sd20, 16'd25, 2'b10);
    set_port(0, 1, 1'b1, -16'sd10, -16'sd5, 2'b00);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_g0_c%0d", i), 32'(i0.req_ready), 32'(i % 2 == 0));
      chk($sformatf("t2_g1_c%0d", i), 32'(i1.req_ready), 32'(i % 2 == 1));
      if (i == 1) chk("t2_sub", 32'(i0.rsp_result), 32'hFFD3);
      if (i == 2) chk("t2_and", 32'(i1.rsp_result), 32'hFFF2);
      tick();
    end
    set_port(0, 0, 1'b0, 16'h0, 16'h0, 2'b00);
    set_port(0, 1, 1'b0, 16'h0, 16'h0, 2'b00);
    tick();

    // Backpressure on port 1, port 0 keeps flowing
    set_port(0, 1, 1'b1, 16'd15, -16'sd10, 2'b01);
    i1.rsp_ready = 1'b0;
    #1 chk("t3_accept", 32'(i1.req_ready), 32'h1);
    tick();
    set_port(0, 1, 1'b1, 16'd3, 16'd4, 2'b01);
    set_port(0, 0, 1'b1, 16'd1, 16'd2, 2'b01);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_hold_result", 32'(i1.rsp_result), 32'd5);
      chk("t3_hold_valid", 32'(i1.rsp_valid), 32'h1);
      chk("t3_bp_ready1", 32'(i1.req_ready), 32'h0);
      chk("t3_ready0", 32'(i0.req_ready), 32'h1);
      tick();
    end
    i1.rsp_ready = 1'b1;
    #1;
    chk("t3_regrant1", 32'(i1.req_ready), 32'h1);
    chk("t3_regrant0", 32'(i0.req_ready), 32'h0);
    tick();
    set_port(0, 0, 1'b0, 16'h0, 16'h0, 2'b00);
    set_port(0, 1, 1'b0, 16'h0, 16'h0, 2'b00);
    #1 chk("t3_new_result", 32'(i1.rsp_result), 32'd7);
    tick();

    // Two's-complement wrap and reserved op
    set_port(0, 0, 1'b1, 16'h7FFF, 16'h0001, 2'b01);
    tick();
    set_port(0, 0, 1'b1, 16'h8000, 16'h0001, 2'b10);
    #1 chk("t5_add_wrap", 32'(i0.rsp_result), 32'h8000);
    tick();
    set_port(0, 0, 1'b1, 16'h1234, 16'h5678, 2'b11);
    #1 chk("t5_sub_wrap", 32'(i0.rsp_result), 32'h7FFF);
    tick();
    set_port(0, 0, 1'b0, 16'h0, 16'h0, 2'b00);
    #1;
    chk("t5_op11", 32'(i0.rsp_result), 32'h0);
    chk("t5_op11_valid", 32'(i0.rsp_valid), 32'h1);
    tick();

    // Reset while a response is pending and port 1 is granted
    set_port(0, 0, 1'b1, 16'd5, 16'd5, 2'b01);
    i0.rsp_ready = 1'b0;
    tick();
    set_port(0, 0, 1'b0, 16'h0, 16'h0, 2'b00);
    set_port(0, 1, 1'b1, 16'd2, 16'd2, 2'b01);
    reset = 1'b1;
    #1;
    chk("t6_pending", 32'(i0.rsp_valid), 32'h1);
    chk("t6_grant1", 32'(i1.req_ready), 32'h1);
    tick();
    reset = 1'b0;
    set_port(0, 1, 1'b0, 16'h0, 16'h0, 2'b00);
    i0.rsp_ready = 1'b1;
    #1;
    chk("t6_valid0", 32'(i0.rsp_valid), 32'h0);
    chk("t6_valid1", 32'(i1.rsp_valid), 32'h0);
    chk("t6_result0", 32'(i0.rsp_result), 32'h0);
    chk("t6_result1", 32'(i1.rsp_result), 32'h0);
    set_port(0, 0, 1'b1, 16'd1, 16'd1, 2'b01);
    set_port(0, 1, 1'b1, 16'd1, 16'd1, 2'b01);
    #1;
    chk("t6_conflict0", 32'(i0.req_ready), 32'h1);
    chk("t6_conflict1", 32'(i1.req_ready), 32'h0);
    tick();
    set_port(0, 0, 1'b0, 16'h0, 16'h0, 2'b00);
    set_port(0, 1, 1'b0, 16'h0, 16'h0, 2'b00);
    tick();

    // Fixed priority: port 0 wins every conflict
    set_port(1, 0, 1'b1, 16'd100, 16'd1, 2'b01);
    set_port(1, 1, 1'b1, 16'd200, 16'd1, 2'b10);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t4_g0_c%0d", i), 32'(f0.req_ready), 32'h1);
      chk($sformatf("t4_g1_c%0d", i), 32'(f1.req_ready), 32'h0);
      tick();
    end
    set_port(1, 0, 1'b0, 16'h0, 16'h0, 2'b00);
    set_port(1, 1, 1'b0, 16'h0, 16'h0, 2'b00);
    #1 chk("t4_result0", 32'(f0.rsp_result), 32'd101);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
